// File: rtl/counter_sweep_pkg.sv
// Shared definitions for the triangular sweep controller: state encodings
// and default datapath widths.
package counter_sweep_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_PASS_W = 4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_UP   = 3'd2;
  localparam logic [2:0] ST_DOWN = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_LOAD = ST_LOAD,
    S_UP   = ST_UP,
    S_DOWN = ST_DOWN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/sweep_count_dp.sv
// WIDTH-bit up/down counter register with synchronous load; load wins over
// count enable.
module sweep_count_dp #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= up ? count + WIDTH'(1) : count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sequences an up/down counter through lo->hi->lo triangular passes with a
// start/busy/done handshake and a rejection pulse for invalid requests.
module counter_sweep_ctrl
  import counter_sweep_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int PASS_W = DEF_PASS_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [PASS_W-1:0] passes,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WIDTH-1:0]  count,
  output logic              dir,
  output logic [PASS_W-1:0] pass_cnt
);

  state_t              state;
  logic [WIDTH-1:0]    lo_q;
  logic [WIDTH-1:0]    hi_q;
  logic [PASS_W-1:0]   passes_q;
  logic [PASS_W-1:0]   pass_next;
  logic                at_hi;
  logic                at_lo;
  logic                last_pass;

  logic                dp_load;
  logic                dp_en;
  logic                dp_up;
  logic [WIDTH-1:0]    dp_val;

  assign at_hi     = (count == hi_q);
  assign at_lo     = (count == lo_q);
  assign pass_next = pass_cnt + PASS_W'(1);
  assign last_pass = (pass_next == passes_q);

  // NOTE: every always_comb output gets a default first so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    dp_load = 1'b0;
    dp_val  = lo_q;
    dp_en   = 1'b0;
    dp_up   = 1'b1;
    unique case (state)
      S_LOAD: dp_load = 1'b1;
      S_UP: begin
        if (!hold) begin
          dp_en = 1'b1;
          dp_up = !at_hi;
        end
      end
      S_DOWN: begin
        if (!hold && !at_lo) begin
          dp_en = 1'b1;
          dp_up = 1'b0;
        end else if (!hold && !last_pass) begin
          // lo was just visited; the next pass restarts one above it
          dp_load = 1'b1;
          dp_val  = lo_q + WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      passes_q <= '0;
      pass_cnt <= '0;
      dir      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            lo_q     <= lo;
            hi_q     <= hi;
            passes_q <= passes;
            if (lo >= hi || passes == '0) begin
              err <= 1'b1;
            end else begin
              state    <= S_LOAD;
              pass_cnt <= '0;
              busy     <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          dir   <= 1'b1;
          state <= S_UP;
        end
        S_UP: begin
          if (!hold && at_hi) begin
            dir   <= 1'b0;
            state <= S_DOWN;
          end
        end
        S_DOWN: begin
          if (!hold && at_lo) begin
            pass_cnt <= pass_next;
            if (last_pass) begin
              dir   <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              dir   <= 1'b1;
              state <= S_UP;
            end
          end
        end
        S_DONE: begin
          dir   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  sweep_count_dp #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .rst_n    (reset),
    .load     (dp_load),
    .load_val (dp_val),
    .en       (dp_en),
    .up       (dp_up),
    .count    (count)
  );

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed self-checking bench for counter_sweep_ctrl with hand-computed
// expected sequences.
module tb_counter_sweep_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [3:0] passes;
  logic       hold;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] count;
  logic       dir;
  logic [3:0] pass_cnt;

  int checks   = 0;
  int failures = 0;

  counter_sweep_ctrl #(.WIDTH(4), .PASS_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .lo       (lo),
    .hi       (hi),
    .passes   (passes),
    .hold     (hold),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .count    (count),
    .dir      (dir),
    .pass_cnt (pass_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then settle before sampling/driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] seq [$];
    int dones;

    reset = 1'b0; start = 1'b0; lo = '0; hi = '0; passes = '0; hold = 1'b0;

    // reset held for two cycles
    tick(); tick();
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    tick();
    check("idle_count", count, 0);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_err", err, 0);
    check("idle_dir", dir, 0);
    check("idle_pass", pass_cnt, 0);

    // lo=2 hi=4 one pass
    lo = 4'd2; hi = 4'd4; passes = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("s1_load_busy", busy, 1);
    check("s1_load_dir", dir, 0);
    seq = '{4'd2, 4'd3, 4'd4, 4'd3, 4'd2};
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("s1_count%0d", i), count, seq[i]);
      check($sformatf("s1_dir%0d", i), dir, (i < 3) ? 1 : 0);
      check($sformatf("s1_done%0d", i), done, 0);
    end
    tick();
    check("s1_done", done, 1);
    check("s1_pass", pass_cnt, 1);
    check("s1_count_hold", count, 2);
    check("s1_busy_done", busy, 1);
    tick();
    check("s1_done_fall", done, 0);
    check("s1_busy_fall", busy, 0);
    check("s1_count_keep", count, 2);

    // full range, two passes: 0..15..0 then 1..15..0
    lo = 4'd0; hi = 4'd15; passes = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    lo = 4'd7; hi = 4'd8; passes = 4'd9;  // post-acceptance changes must not matter
    seq = {};
    for (int v = 0; v <= 15; v++) seq.push_back(4'(v));
    for (int v = 14; v >= 0; v--) seq.push_back(4'(v));
    for (int v = 1; v <= 15; v++) seq.push_back(4'(v));
    for (int v = 14; v >= 0; v--) seq.push_back(4'(v));
    dones = 0;
    for (int i = 0; i < seq.size(); i++) begin
      tick();
      if (done) dones++;
      check($sformatf("s2_count%0d", i), count, seq[i]);
    end
    check("s2_pass_mid", pass_cnt, 1);
    tick();
    if (done) dones++;
    check("s2_done", done, 1);
    check("s2_pass", pass_cnt, 2);
    tick();
    if (done) dones++;
    check("s2_busy_fall", busy, 0);
    check("s2_done_pulses", dones, 1);

    // rejected starts: lo==hi, passes==0, lo>hi
    lo = 4'd5; hi = 4'd5; passes = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("e1_err", err, 1);
    check("e1_busy", busy, 0);
    tick();
    check("e1_err_fall", err, 0);
    check("e1_busy2", busy, 0);
    lo = 4'd1; hi = 4'd3; passes = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("e2_err", err, 1);
    check("e2_busy", busy, 0);
    tick();
    check("e2_err_fall", err, 0);
    lo = 4'd9; hi = 4'd3; passes = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("e3_err", err, 1);
    check("e3_busy", busy, 0);
    tick();

    // hold while going up at count=2, plus start while busy
    lo = 4'd1; hi = 4'd3; passes = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("h_count1", count, 1);
    tick();
    check("h_count2", count, 2);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("h_frozen_count%0d", i), count, 2);
      check($sformatf("h_frozen_dir%0d", i), dir, 1);
    end
    hold = 1'b0;
    lo = 4'd0; hi = 4'd9; passes = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("h_resume3", count, 3);
    check("h_resume_dir", dir, 1);
    tick();
    check("h_down2", count, 2);
    check("h_down_dir", dir, 0);
    tick();
    check("h_down1", count, 1);
    tick();
    check("h_done", done, 1);
    check("h_pass", pass_cnt, 1);
    tick();
    check("h_busy_fall", busy, 0);

    // reset mid-DOWN at count=3
    lo = 4'd0; hi = 4'd5; passes = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("r_pre_count", count, 3);
    check("r_pre_dir", dir, 0);
    reset = 1'b0;
    #2;
    check("r_count", count, 0);
    check("r_busy", busy, 0);
    check("r_done", done, 0);
    check("r_dir", dir, 0);
    tick();
    reset = 1'b1;
    tick();
    check("r_no_done", done, 0);
    check("r_idle_busy", busy, 0);

    // fresh sweep after abort
    lo = 4'd2; hi = 4'd4; passes = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    seq = '{4'd2, 4'd3, 4'd4, 4'd3, 4'd2};
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("f_count%0d", i), count, seq[i]);
    end
    tick();
    check("f_done", done, 1);
    tick();
    check("f_busy_fall", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_sweep_ctrl.md
# counter_sweep_ctrl

Controller that sequences a WIDTH-bit up/down counter through a programmable triangular sweep: count up from `lo` to `hi`, back down to `lo`, repeated `passes` times, with a start/busy/done handshake. It sits in front of the counter datapath and owns its load, enable and direction controls, so software-style requesters only supply bounds and a start pulse.

## Interface
- `WIDTH`, 4, counter and bound width
- `PASS_W`, 4, width of pass count
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  request a sweep; sampled only in IDLE
- `lo`  in  WIDTH  lower bound, latched on accepted start
- `hi`  in  WIDTH  upper bound, latched on accepted start
- `passes`  in  PASS_W  number of up/down passes, latched on accepted start
- `hold`  in  1  freeze count and state while in UP/DOWN
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  high for exactly one cycle (DONE state)
- `err`  out  1  one-cycle pulse: start rejected
- `count`  out  WIDTH  counter value
- `dir`  out  1  1 = counting up, 0 = down/idle
- `pass_cnt`  out  PASS_W  completed passes in current sweep

## Operation
- States: IDLE, LOAD, UP, DOWN, DONE.
- IDLE: on `start`=1, latch `lo`/`hi`/`passes`. If `lo >= hi` or `passes == 0`: `err`=1 for the next cycle, stay IDLE. Otherwise go to LOAD and clear `pass_cnt`.
- LOAD: `count <= lo_q`, `dir <= 1`, go to UP.
- UP: if `count != hi_q`, `count+1`; else `count-1`, `dir <= 0`, go to DOWN.
- DOWN: if `count != lo_q`, `count-1`; else `pass_cnt+1`. If the new `pass_cnt == passes_q`, go to DONE with `count` held at lo. Otherwise `count <= lo_q+1`, `dir <= 1`, go to UP.
- DONE: `done`=1, `dir`=0, go to IDLE. `count` keeps its last value (lo) until the next LOAD.
- `hold`=1 in UP/DOWN freezes `count`, `dir`, `pass_cnt` and state. `hold` is ignored in other states.
- `start` while busy is ignored. Inputs `lo`/`hi`/`passes` may change freely after acceptance.
- No wrap-around is possible: `count` stays within [lo, hi] and bounds are unsigned.

## Timing
- Reset (`reset`=0, async): state IDLE, `count`=0, `dir`=0, `pass_cnt`=0, `busy`=`done`=`err`=0. Reset deasserts synchronously into IDLE.
- Reset mid-sweep aborts immediately; no `done`.
- All outputs are registered.
- Start accepted at edge E: LOAD after E, `count`=lo after E+1.
- One pass takes 2·(hi−lo) cycles. `lo` is visited once between consecutive passes.
- Final DOWN reaches lo, then DONE on the next edge. `busy` falls one edge after that.
- `err` is asserted after edge E for one cycle, with `busy` staying 0.
- `done` and `start` in the same cycle: `start` is ignored, because the state is not IDLE.

## Structure
- Shared package `counter_sweep_pkg`: state encodings (3-bit localparams ST_IDLE..ST_DONE) and default WIDTH/PASS_W.
- One sub-module, `sweep_count_dp`: a WIDTH-bit register with `load`, `load_val`, `en`, `up` controls and the same async active-low reset. The FSM, bound latches and pass counter stay in `counter_sweep_ctrl`.

## Test plan
- Reset held low 2 cycles, release → all outputs 0, `busy`=0.
- lo=2, hi=4, passes=1, start at E → `count` 2,3,4,3,2 after E+1..E+5; `dir` 1,1,1,0,0; `done`=1 after E+6 only; `busy`=0 after E+7; `pass_cnt`=1.
- lo=0, hi=15, passes=2 → sequence 0..15..0, then 1..15..0; exactly one `done`; `count` never leaves [0,15].
- lo=5, hi=5, start → `err`=1 for one cycle, `busy` stays 0. Repeat with passes=0 → same.
- lo=1, hi=3, hold=1 for 3 cycles while `count`=2 going up → `count` stays 2 and `dir` stays 1; on release the sweep resumes 3,2,1. Also pulse `start` while busy → no effect.
- Drop `reset` mid-DOWN with `count`=3 → immediately `count`=0, `busy`=0, no `done`. A fresh start then sweeps normally.
